// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// Lane indices, the null register and the buffered entry layout.
package wb_pkg;

  localparam int N_LANES  = 3;
  localparam int LANE_MEM = 0;
  localparam int LANE_IO  = 1;
  localparam int LANE_ALU = 2;

  localparam logic [5:0] REG_NONE = 6'd0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] val;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Result streams in, register-file write port and status out.
// slave: arbiter side; master: producer/consumer side.
interface wb_arbiter_if;

  logic [5:0]  alu_addr;
  logic [31:0] alu_val;
  logic [5:0]  mem_addr;
  logic [31:0] mem_val;
  logic [5:0]  io_addr;
  logic [31:0] io_val;
  logic        rf_we;
  logic [5:0]  rf_addr;
  logic [31:0] rf_val;
  logic        wb_stall;
  logic        wb_ovf;

  modport slave (
    input  alu_addr, alu_val,
    input  mem_addr, mem_val,
    input  io_addr,  io_val,
    output rf_we, rf_addr, rf_val,
    output wb_stall, wb_ovf
  );

  modport master (
    output alu_addr, alu_val,
    output mem_addr, mem_val,
    output io_addr,  io_val,
    input  rf_we, rf_addr, rf_val,
    input  wb_stall, wb_ovf
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Per-lane result FIFO with natural-wrap pointers.
// Push while full is ignored unless a pop frees the slot.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  wb_entry_t                i_din,
  output wb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [CW-1:0]     r_count;
  logic              w_wr;

  assign o_full  = (r_count == CW'(DEPTH));
  assign w_wr    = i_push && (!o_full || i_pop);
  assign o_head  = r_mem[r_rp];
  assign o_count = r_count;

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp] <= i_din;
  end

  // Pointers and occupancy, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)
        r_wp <= r_wp + 1'b1;
      if (i_pop)
        r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges MEM, IO and ALU results onto one register-file write port.
// Fixed priority MEM > IO > ALU; losers wait in per-lane FIFOs.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SLACK = 5
) (
  input  logic         clk,
  input  logic         rstn,
  wb_arbiter_if.slave  wb
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t            w_in    [N_LANES];
  wb_entry_t            w_head  [N_LANES];
  wb_entry_t            w_cand  [N_LANES];
  logic [CW-1:0]        w_count [N_LANES];
  logic [N_LANES-1:0]   w_full;
  logic [N_LANES-1:0]   w_empty;
  logic [N_LANES-1:0]   w_req;
  logic [N_LANES-1:0]   w_grant;
  logic [N_LANES-1:0]   w_push;
  logic [N_LANES-1:0]   w_pop;
  wb_entry_t            w_win;
  logic                 w_any;
  logic                 w_drop;
  logic                 w_stall;

  logic                 r_we;
  logic [5:0]           r_addr;
  logic [31:0]          r_val;
  logic                 r_ovf;

  assign w_in[LANE_MEM] = '{addr: wb.mem_addr, val: wb.mem_val};
  assign w_in[LANE_IO]  = '{addr: wb.io_addr,  val: wb.io_val};
  assign w_in[LANE_ALU] = '{addr: wb.alu_addr, val: wb.alu_val};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_mem (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push[LANE_MEM]),
    .i_pop   (w_pop[LANE_MEM]),
    .i_din   (w_in[LANE_MEM]),
    .o_head  (w_head[LANE_MEM]),
    .o_count (w_count[LANE_MEM]),
    .o_full  (w_full[LANE_MEM])
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_io (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push[LANE_IO]),
    .i_pop   (w_pop[LANE_IO]),
    .i_din   (w_in[LANE_IO]),
    .o_head  (w_head[LANE_IO]),
    .o_count (w_count[LANE_IO]),
    .o_full  (w_full[LANE_IO])
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_alu (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push[LANE_ALU]),
    .i_pop   (w_pop[LANE_ALU]),
    .i_din   (w_in[LANE_ALU]),
    .o_head  (w_head[LANE_ALU]),
    .o_count (w_count[LANE_ALU]),
    .o_full  (w_full[LANE_ALU])
  );

  // Per-lane request and candidate: FIFO head first, else bypass.
  always_comb begin
    w_empty = '0;
    w_req   = '0;
    for (int l = 0; l < N_LANES; l++) begin
      w_empty[l] = (w_count[l] == '0);
      w_req[l]   = !w_empty[l] || (w_in[l].addr != REG_NONE);
      w_cand[l]  = w_empty[l] ? w_in[l] : w_head[l];
    end
  end

  // Fixed-priority grant, one-hot so the select below is exclusive.
  always_comb begin
    w_grant           = '0;
    w_grant[LANE_MEM] = w_req[LANE_MEM];
    w_grant[LANE_IO]  = w_req[LANE_IO] && !w_req[LANE_MEM];
    w_grant[LANE_ALU] = w_req[LANE_ALU] && !w_req[LANE_MEM]
                        && !w_req[LANE_IO];
    w_any             = |w_req;
  end

  // Select the winning candidate.
  always_comb begin
    w_win = '0;
    unique case (1'b1)
      w_grant[LANE_MEM]: w_win = w_cand[LANE_MEM];
      w_grant[LANE_IO]:  w_win = w_cand[LANE_IO];
      w_grant[LANE_ALU]: w_win = w_cand[LANE_ALU];
      default:           w_win = '0;
    endcase
  end

  // FIFO control: winner pops its head, a bypassing winner never pushes.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    w_drop = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      w_pop[l]  = w_grant[l] && !w_empty[l];
      w_push[l] = (w_in[l].addr != REG_NONE)
                  && !(w_grant[l] && w_empty[l]);
      w_drop    = w_drop || (w_push[l] && w_full[l] && !w_pop[l]);
    end
  end

  // Stall once any lane can no longer absorb in-flight results.
  always_comb begin
    w_stall = 1'b0;
    for (int l = 0; l < N_LANES; l++)
      w_stall = w_stall || (int'(w_count[l]) > DEPTH - SLACK);
  end

  // Register-file write port; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_val  <= '0;
    end else begin
      r_we <= w_any;
      if (w_any) begin
        r_addr <= w_win.addr;
        r_val  <= w_win.val;
      end
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rstn)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
  end

  assign wb.rf_we    = r_we;
  assign wb.rf_addr  = r_addr;
  assign wb.rf_val   = r_val;
  assign wb.wb_stall = w_stall;
  assign wb.wb_ovf   = r_ovf;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(8), .SLACK(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .wb   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] ma, input logic [31:0] mv,
                       input logic [5:0] ia, input logic [31:0] iv,
                       input logic [5:0] aa, input logic [31:0] av);
    bus.mem_addr = ma;
    bus.mem_val  = mv;
    bus.io_addr  = ia;
    bus.io_val   = iv;
    bus.alu_addr = aa;
    bus.alu_val  = av;
  endtask

  task automatic idle();
    drive(6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0);
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_we",    32'(bus.rf_we),    32'd0);
    chk("rst_addr",  32'(bus.rf_addr),  32'd0);
    chk("rst_val",   bus.rf_val,        32'd0);
    chk("rst_ovf",   32'(bus.wb_ovf),   32'd0);
    chk("rst_stall", 32'(bus.wb_stall), 32'd0);
    rstn = 1'b1;
    tick();
    chk("idle_we", 32'(bus.rf_we), 32'd0);

    // single uncontended ALU write
    drive(6'd0, 32'h0, 6'd0, 32'h0, 6'd5, 32'h1234);
    tick();
    idle();
    chk("alu1_we",   32'(bus.rf_we),   32'd1);
    chk("alu1_addr", 32'(bus.rf_addr), 32'd5);
    chk("alu1_val",  bus.rf_val,       32'h1234);
    tick();
    chk("alu1_we0",   32'(bus.rf_we),   32'd0);
    chk("alu1_hold",  32'(bus.rf_addr), 32'd5);

    // three lanes in one cycle
    drive(6'd3, 32'hAAAA, 6'd4, 32'hBB, 6'd7, 32'h1);
    tick();
    idle();
    chk("tri0_addr", 32'(bus.rf_addr), 32'd3);
    chk("tri0_val",  bus.rf_val,       32'hAAAA);
    chk("tri0_acnt", 32'(dut.u_fifo_alu.o_count), 32'd1);
    chk("tri0_icnt", 32'(dut.u_fifo_io.o_count),  32'd1);
    tick();
    chk("tri1_we",   32'(bus.rf_we),   32'd1);
    chk("tri1_addr", 32'(bus.rf_addr), 32'd4);
    chk("tri1_val",  bus.rf_val,       32'hBB);
    chk("tri1_acnt", 32'(dut.u_fifo_alu.o_count), 32'd1);
    tick();
    chk("tri2_addr", 32'(bus.rf_addr), 32'd7);
    chk("tri2_val",  bus.rf_val,       32'h1);
    chk("tri2_acnt", 32'(dut.u_fifo_alu.o_count), 32'd0);
    tick();
    chk("tri3_we", 32'(bus.rf_we), 32'd0);

    // MEM r1..r6 against ALU every cycle
    for (int i = 0; i < 6; i++) begin
      drive(6'(i + 1), 32'h200 + i, 6'd0, 32'h0,
            6'(10 + i), 32'h100 + i);
      tick();
      chk("mx_addr",  32'(bus.rf_addr), 32'(i + 1));
      chk("mx_val",   bus.rf_val,       32'h200 + i);
      chk("mx_acnt",  32'(dut.u_fifo_alu.o_count), 32'(i + 1));
      chk("mx_stall", 32'(bus.wb_stall), (i >= 3) ? 32'd1 : 32'd0);
    end
    idle();
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("dr_we",    32'(bus.rf_we),   32'd1);
      chk("dr_addr",  32'(bus.rf_addr), 32'(10 + j));
      chk("dr_val",   bus.rf_val,       32'h100 + j);
      chk("dr_stall", 32'(bus.wb_stall), (5 - j > 3) ? 32'd1 : 32'd0);
    end
    tick();
    chk("dr_end_we", 32'(bus.rf_we), 32'd0);

    // null destination: no write, no push
    drive(6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 32'hDEAD);
    tick();
    idle();
    chk("null_we",   32'(bus.rf_we), 32'd0);
    chk("null_acnt", 32'(dut.u_fifo_alu.o_count), 32'd0);
    chk("null_hold", bus.rf_val, 32'h105);

    // overflow: 9 ALU pushes behind a busy MEM lane
    for (int i = 0; i < 9; i++) begin
      drive(6'(30 + i), 32'h300 + i, 6'd0, 32'h0,
            6'(20 + i), 32'h400 + i);
      tick();
      chk("ov_addr", 32'(bus.rf_addr), 32'(30 + i));
      chk("ov_acnt", 32'(dut.u_fifo_alu.o_count),
          (i < 8) ? 32'(i + 1) : 32'd8);
      chk("ov_flag", 32'(bus.wb_ovf), (i == 8) ? 32'd1 : 32'd0);
    end
    idle();
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("ovd_addr", 32'(bus.rf_addr), 32'(20 + j));
      chk("ovd_val",  bus.rf_val,       32'h400 + j);
    end
    tick();
    chk("ovd_we0",  32'(bus.rf_we),  32'd0);
    chk("ovd_ovf",  32'(bus.wb_ovf), 32'd1);

    // reset with ALU entries buffered
    for (int i = 0; i < 3; i++) begin
      drive(6'(40 + i), 32'h500 + i, 6'd0, 32'h0,
            6'(50 + i), 32'h600 + i);
      tick();
    end
    idle();
    chk("pre_acnt", 32'(dut.u_fifo_alu.o_count), 32'd3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mr_we",    32'(bus.rf_we),    32'd0);
    chk("mr_addr",  32'(bus.rf_addr),  32'd0);
    chk("mr_val",   bus.rf_val,        32'd0);
    chk("mr_stall", 32'(bus.wb_stall), 32'd0);
    chk("mr_ovf",   32'(bus.wb_ovf),   32'd0);
    chk("mr_acnt",  32'(dut.u_fifo_alu.o_count), 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("post_we", 32'(bus.rf_we), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
